// File: rtl/time_adjust_ctrl.sv
// time_adjust_ctrl: adjust-mode controller for the alarm clock.
// Edits the current time plus NUM_ALARMS alarms, stored as 24h binary hour/minute
// pairs, and derives the 12h display form on the way out.
// Optional feature macro: TIME_ADJUST_AUTO_REPEAT_EN (hold-to-repeat stepping).
// Handshake: b_next/b_up/b_dn are single-cycle strobes that are only acted on in
// ADJ while en=1; commit is a one-cycle strobe with no back-pressure, and the
// edited values are stable on time_out/alm_out from that cycle on.
module time_adjust_ctrl #(
  parameter int         NUM_ALARMS   = 2,
  parameter logic [7:0] CLK_RST_HR   = 8'd0,
  parameter logic [7:0] ALM_RST_HR   = 8'd23,
  parameter logic [7:0] ALM_RST_MIN  = 8'd59,
  parameter int         REPEAT_DELAY = 25000000,
  parameter int         REPEAT_RATE  = 5000000
) (
  input  logic                    clk,
  input  logic                    RESET_N,
  input  logic                    en,
  input  logic                    mode12,
  input  logic                    b_next,
  input  logic                    b_up,
  input  logic                    b_dn,
  input  logic                    b_up_lvl,
  input  logic                    b_dn_lvl,
  input  logic [15:0]             time_in,
  input  logic [16*NUM_ALARMS-1:0] alm_in,
  output logic [15:0]             time_out,
  output logic [16*NUM_ALARMS-1:0] alm_out,
  output logic [2*NUM_ALARMS+1:0] cursor,
  output logic [7:0]              disp_hr,
  output logic [7:0]              disp_min,
  output logic                    disp_pm,
  output logic                    busy,
  output logic                    commit,
  output logic [1:0]              dbg_state
);

  localparam int F = 2 + 2*NUM_ALARMS;  // editable fields
  localparam int E = NUM_ALARMS + 1;    // entities: 0 = clock, k+1 = alarm k

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ADJ    = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [7:0]   r_hr  [E];
  logic [7:0]   r_min [E];
  logic [7:0]   w_hr_nxt  [E];
  logic [7:0]   w_min_nxt [E];
  logic [F-1:0] r_cursor, w_cursor_nxt;
  logic         w_adj_act, w_rep_up, w_rep_dn, w_inc, w_dec;
  logic [7:0]   w_disp_hr24;

  // Wrap-around step helpers; 'top' is the largest legal value (23 or 59).
  function automatic logic [7:0] f_wrap_inc(input logic [7:0] v, input logic [7:0] top);
    return (v >= top) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic logic [7:0] f_wrap_dec(input logic [7:0] v, input logic [7:0] top);
    return (v == 8'd0 || v > top) ? top : v - 8'd1;
  endfunction

  // Out-of-range captured values load as zero.
  function automatic logic [7:0] f_sanitize(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? 8'd0 : v;
  endfunction

  // Buttons only count in ADJ with en still high; en=0 wins over any button.
  assign w_adj_act = (r_state == S_ADJ) && en;
  // Opposing steps in the same cycle cancel.
  assign w_inc = w_adj_act && (b_up || w_rep_up) && !(b_dn || w_rep_dn);
  assign w_dec = w_adj_act && (b_dn || w_rep_dn) && !(b_up || w_rep_up);

`ifdef TIME_ADJUST_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = (RMAX < 2) ? 1 : $clog2(RMAX + 1);

  logic [CW-1:0] r_rep_cnt, w_rep_cnt_inc;
  logic          r_rep_armed, w_rep_hold, w_rep_fire;

  // Exactly one level held, no cursor move, still editing.
  assign w_rep_hold    = w_adj_act && (b_up_lvl ^ b_dn_lvl) && !b_next;
  assign w_rep_cnt_inc = r_rep_cnt + CW'(1);
  // First step after REPEAT_DELAY held cycles, then every REPEAT_RATE cycles.
  assign w_rep_fire    = w_rep_hold &&
                         (r_rep_armed ? (w_rep_cnt_inc == CW'(REPEAT_RATE))
                                      : (w_rep_cnt_inc == CW'(REPEAT_DELAY)));
  assign w_rep_up      = w_rep_fire && b_up_lvl;
  assign w_rep_dn      = w_rep_fire && b_dn_lvl;

  // Hold-time counter for auto-repeat; any interruption starts over from the delay.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if (!w_rep_hold) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b1;
    end else begin
      r_rep_cnt   <= w_rep_cnt_inc;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{b_up_lvl, b_dn_lvl, REPEAT_DELAY[0], REPEAT_RATE[0]};
  assign w_rep_up     = 1'b0;
  assign w_rep_dn     = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state: every transition takes one clock.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (en)  w_state_nxt = S_LOAD;
      S_LOAD:            w_state_nxt = S_ADJ;
      S_ADJ:    if (!en) w_state_nxt = S_COMMIT;
      S_COMMIT:          w_state_nxt = S_IDLE;
      default:           w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs (Moore).
  always_comb begin
    busy      = (r_state == S_LOAD) || (r_state == S_ADJ);
    commit    = (r_state == S_COMMIT);
    dbg_state = r_state;
  end

  // Edit-register next values: capture in LOAD, step/rotate in ADJ, hold otherwise.
  always_comb begin
    for (int e = 0; e < E; e++) begin
      w_hr_nxt[e]  = r_hr[e];
      w_min_nxt[e] = r_min[e];
    end
    w_cursor_nxt = r_cursor;
    if (r_state == S_LOAD) begin
      w_hr_nxt[0]  = f_sanitize(time_in[15:8], 8'd24);
      w_min_nxt[0] = f_sanitize(time_in[7:0], 8'd60);
      for (int k = 0; k < NUM_ALARMS; k++) begin
        w_hr_nxt[k+1]  = f_sanitize(alm_in[16*k+8 +: 8], 8'd24);
        w_min_nxt[k+1] = f_sanitize(alm_in[16*k +: 8], 8'd60);
      end
      w_cursor_nxt = F'(1);
    end else if (w_adj_act) begin
      // The step uses the cursor before any b_next rotation this cycle.
      for (int e = 0; e < E; e++) begin
        if (r_cursor[2*e]) begin
          if (w_inc)      w_hr_nxt[e] = f_wrap_inc(r_hr[e], 8'd23);
          else if (w_dec) w_hr_nxt[e] = f_wrap_dec(r_hr[e], 8'd23);
        end
        if (r_cursor[2*e+1]) begin
          if (w_inc)      w_min_nxt[e] = f_wrap_inc(r_min[e], 8'd59);
          else if (w_dec) w_min_nxt[e] = f_wrap_dec(r_min[e], 8'd59);
        end
      end
      if (b_next) w_cursor_nxt = {r_cursor[F-2:0], r_cursor[F-1]};
    end
  end

  // Edit registers and cursor.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hr[0]  <= CLK_RST_HR;
      r_min[0] <= 8'd0;
      for (int k = 1; k < E; k++) begin
        r_hr[k]  <= ALM_RST_HR;
        r_min[k] <= ALM_RST_MIN;
      end
      r_cursor <= F'(1);
    end else begin
      for (int e = 0; e < E; e++) begin
        r_hr[e]  <= w_hr_nxt[e];
        r_min[e] <= w_min_nxt[e];
      end
      r_cursor <= w_cursor_nxt;
    end
  end

  // Pack edited values back into the bus layout of the inputs.
  always_comb begin
    time_out = {r_hr[0], r_min[0]};
    alm_out  = '0;
    for (int k = 0; k < NUM_ALARMS; k++) alm_out[16*k +: 16] = {r_hr[k+1], r_min[k+1]};
    cursor   = r_cursor;
  end

  // Pick the entity that owns the cursor; the clock owns bits 1:0.
  always_comb begin
    w_disp_hr24 = r_hr[0];
    disp_min    = r_min[0];
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (r_cursor[1:0] == 2'b00 && (r_cursor[2+2*k] || r_cursor[3+2*k])) begin
        w_disp_hr24 = r_hr[k+1];
        disp_min    = r_min[k+1];
      end
    end
  end

  // 12h conversion for display only: 0 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
  always_comb begin
    if (!mode12)                  disp_hr = w_disp_hr24;
    else if (w_disp_hr24 == 8'd0) disp_hr = 8'd12;
    else if (w_disp_hr24 > 8'd12) disp_hr = w_disp_hr24 - 8'd12;
    else                          disp_hr = w_disp_hr24;
    disp_pm = mode12 && (w_disp_hr24 >= 8'd12);
  end

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Bench for time_adjust_ctrl: directed vectors, a cycle model of the adjust
// behaviour in plain integer arithmetic, and literal spot checks.
module tb_time_adjust_ctrl;
  localparam int NA = 2;
  localparam int F  = 2 + 2*NA;
  localparam int RD = 10;
  localparam int RR = 4;

  logic clk, RESET_N, en, mode12, b_next, b_up, b_dn, b_up_lvl, b_dn_lvl;
  logic [15:0]     time_in;
  logic [16*NA-1:0] alm_in;
  logic [15:0]     time_out;
  logic [16*NA-1:0] alm_out;
  logic [F-1:0]    cursor;
  logic [7:0]      disp_hr, disp_min;
  logic            disp_pm, busy, commit;
  logic [1:0]      dbg_state_unused;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  time_adjust_ctrl #(
    .NUM_ALARMS(NA), .CLK_RST_HR(8'd0), .ALM_RST_HR(8'd23), .ALM_RST_MIN(8'd59),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .RESET_N(RESET_N), .en(en), .mode12(mode12),
    .b_next(b_next), .b_up(b_up), .b_dn(b_dn), .b_up_lvl(b_up_lvl), .b_dn_lvl(b_dn_lvl),
    .time_in(time_in), .alm_in(alm_in), .time_out(time_out), .alm_out(alm_out),
    .cursor(cursor), .disp_hr(disp_hr), .disp_min(disp_min), .disp_pm(disp_pm),
    .busy(busy), .commit(commit), .dbg_state(dbg_state_unused)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // phase: 0 idle, 1 load, 2 adjust, 3 commit. m_cur is the field index 0..F-1.
  int m_phase, m_cur, m_hold;
  int m_hr [0:NA];
  int m_min[0:NA];

  function automatic int legal(input logic [7:0] v, input int lim);
    return (int'(v) >= lim) ? 0 : int'(v);
  endfunction

  function automatic bit rep_fire(input int n);
    return (n == RD) || (n > RD && ((n - RD) % RR) == 0);
  endfunction

  function automatic bit held_now();
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
    return (b_up_lvl ^ b_dn_lvl) && !b_next;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int step_dir();
    bit fire, up, dn;
    fire = held_now() && rep_fire(m_hold + 1);
    up   = b_up || (fire && b_up_lvl);
    dn   = b_dn || (fire && b_dn_lvl);
    if (up && !dn) return 1;
    if (dn && !up) return -1;
    return 0;
  endfunction

  always @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      m_phase <= 0;
      m_cur   <= 0;
      m_hold  <= 0;
      m_hr[0] <= 0;
      m_min[0] <= 0;
      for (int k = 1; k <= NA; k++) begin
        m_hr[k]  <= 23;
        m_min[k] <= 59;
      end
    end else begin
      case (m_phase)
        0: if (en) m_phase <= 1;
        1: begin
          m_phase  <= 2;
          m_cur    <= 0;
          m_hold   <= 0;
          m_hr[0]  <= legal(time_in[15:8], 24);
          m_min[0] <= legal(time_in[7:0], 60);
          for (int k = 1; k <= NA; k++) begin
            m_hr[k]  <= legal(alm_in[16*(k-1)+8 +: 8], 24);
            m_min[k] <= legal(alm_in[16*(k-1) +: 8], 60);
          end
        end
        2: begin
          if (!en) begin
            m_phase <= 3;
            m_hold  <= 0;
          end else begin
            if (m_cur % 2 == 0) m_hr[m_cur/2]  <= (m_hr[m_cur/2] + step_dir() + 24) % 24;
            else                m_min[m_cur/2] <= (m_min[m_cur/2] + step_dir() + 60) % 60;
            if (b_next) m_cur <= (m_cur + 1) % F;
            m_hold <= held_now() ? m_hold + 1 : 0;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  function automatic logic [15:0] m_pair(input int e);
    return {8'(m_hr[e]), 8'(m_min[e])};
  endfunction

  function automatic logic [16*NA-1:0] m_alm();
    logic [16*NA-1:0] v;
    v = '0;
    for (int k = 0; k < NA; k++) v[16*k +: 16] = m_pair(k + 1);
    return v;
  endfunction

  function automatic logic [7:0] m_disp_hr();
    int h;
    h = m_hr[m_cur/2];
    if (!mode12) return 8'(h);
    if (h % 12 == 0) return 8'd12;
    return 8'(h % 12);
  endfunction

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("time_out", 32'(time_out), 32'(m_pair(0)));
      check("alm_out",  32'(alm_out),  32'(m_alm()));
      check("cursor",   32'(cursor),   32'(1) << m_cur);
      check("disp_hr",  32'(disp_hr),  32'(m_disp_hr()));
      check("disp_min", 32'(disp_min), 32'(m_min[m_cur/2]));
      check("disp_pm",  32'(disp_pm),  32'(mode12 && m_hr[m_cur/2] >= 12));
      check("busy",     32'(busy),     32'(m_phase == 1 || m_phase == 2));
      check("commit",   32'(commit),   32'(m_phase == 3));
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input bit nx, input bit up, input bit dn);
    b_next = nx; b_up = up; b_dn = dn;
    tick();
    b_next = 1'b0; b_up = 1'b0; b_dn = 1'b0;
  endtask

  task automatic enter();
    en = 1'b1;
    ticks(2);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RESET_N = 1'b0; en = 1'b0; mode12 = 1'b0;
    b_next = 1'b0; b_up = 1'b0; b_dn = 1'b0; b_up_lvl = 1'b0; b_dn_lvl = 1'b0;
    time_in = 16'h0000; alm_in = '0;
    ticks(3);
    chk_on = 1'b1;

    // reset values
    check("rst_time",   32'(time_out),      32'h0000);
    check("rst_alm0",   32'(alm_out[15:0]), 32'h173B);
    check("rst_alm1",   32'(alm_out[31:16]), 32'h173B);
    check("rst_cursor", 32'(cursor),        32'h1);
    check("rst_busy",   32'(busy),          32'h0);
    check("rst_commit", 32'(commit),        32'h0);
    RESET_N = 1'b1;
    ticks(2);

    // capture, hour wrap 23->0->1, commit pulse
    time_in = 16'h170A;
    alm_in  = {16'h0C1E, 16'h0530};
    en = 1'b1;
    tick();
    check("load_busy", 32'(busy), 32'h1);
    tick();
    check("cap_time", 32'(time_out), 32'h170A);
    check("cap_alm",  32'(alm_out),  32'h0C1E0530);
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    check("hr_wrap_up", 32'(time_out), 32'h010A);
    en = 1'b0;
    tick();
    check("commit_on",   32'(commit),   32'h1);
    check("commit_time", 32'(time_out), 32'h010A);
    tick();
    check("commit_once", 32'(commit), 32'h0);
    check("idle_busy",   32'(busy),   32'h0);

    // minute wrap down, cursor rotation
    time_in = 16'h0D00;
    enter();
    pulse(1, 0, 0);
    check("cursor_min", 32'(cursor), 32'h2);
    pulse(0, 0, 1);
    check("min_wrap_dn", 32'(time_out), 32'h0D3B);
    for (int i = 0; i < 5; i++) pulse(1, 0, 0);
    check("cursor_wrap", 32'(cursor), 32'h1);

    // 12h display, simultaneous up/down
    mode12 = 1'b1;
    #1;
    check("h13_disp", 32'(disp_hr), 32'd1);
    check("h13_pm",   32'(disp_pm), 32'h1);
    pulse(0, 1, 1);
    check("up_dn_cancel", 32'(time_out), 32'h0D3B);
    pulse(0, 0, 1);
    check("h12_disp", 32'(disp_hr), 32'd12);
    check("h12_pm",   32'(disp_pm), 32'h1);
    for (int i = 0; i < 12; i++) pulse(0, 0, 1);
    check("h0_disp", 32'(disp_hr), 32'd12);
    check("h0_pm",   32'(disp_pm), 32'h0);
    mode12 = 1'b0;
    #1;
    check("h0_24h", 32'(disp_hr), 32'd0);
    pulse(1, 1, 0);
    check("step_then_move", 32'(time_out), 32'h013B);
    check("moved_cursor",   32'(cursor),   32'h2);

    // en drop wins over a button; en held through COMMIT re-enters
    en = 1'b0; b_up = 1'b1;
    tick();
    b_up = 1'b0;
    check("drop_commit", 32'(commit),   32'h1);
    check("drop_ignore", 32'(time_out), 32'h013B);
    en = 1'b1;
    tick();
    check("reenter_idle", 32'(busy), 32'h0);
    tick();
    check("reenter_load", 32'(busy), 32'h1);
    tick();
    check("recapture", 32'(time_out), 32'h0D00);

    // reset mid-edit
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    check("alm_edit", 32'(alm_out), 32'h0C1E0630);
    #1;
    RESET_N = 1'b0;
    #1;
    check("midrst_time",   32'(time_out), 32'h0000);
    check("midrst_alm",    32'(alm_out),  32'h173B173B);
    check("midrst_cursor", 32'(cursor),   32'h1);
    check("midrst_commit", 32'(commit),   32'h0);
    en = 1'b0;
    tick();
    RESET_N = 1'b1;
    ticks(2);
    check("no_commit", 32'(commit), 32'h0);

    // out-of-range capture loads 0
    time_in = 16'h1C3C;
    alm_in  = {16'h181E, 16'h064B};
    enter();
    check("sanitize_time", 32'(time_out), 32'h0000);
    check("sanitize_alm",  32'(alm_out),  32'h001E0600);
    en = 1'b0;
    ticks(2);

    // auto-repeat
    time_in = 16'h0000;
    enter();
    b_up_lvl = 1'b1;
    ticks(21);
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
    check("rep_21", 32'(time_out), 32'h0300);
`else
    check("rep_21", 32'(time_out), 32'h0000);
`endif
    tick();
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
    check("rep_22", 32'(time_out), 32'h0400);
`else
    check("rep_22", 32'(time_out), 32'h0000);
`endif
    b_up_lvl = 1'b0;
    ticks(3);
    b_dn_lvl = 1'b1;
    ticks(8);
    pulse(1, 0, 0);
    ticks(8);
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
    check("rep_next_clear", 32'(time_out), 32'h0400);
`else
    check("rep_next_clear", 32'(time_out), 32'h0000);
`endif
    ticks(2);
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
    check("rep_dn_min", 32'(time_out), 32'h043B);
`else
    check("rep_dn_min", 32'(time_out), 32'h0000);
`endif
    b_up_lvl = 1'b1;
    ticks(12);
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
    check("rep_both", 32'(time_out), 32'h043B);
`else
    check("rep_both", 32'(time_out), 32'h0000);
`endif
    b_up_lvl = 1'b0;
    b_dn_lvl = 1'b0;
    en = 1'b0;
    tick();
    check("final_commit", 32'(commit), 32'h1);
    ticks(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
